// File: rtl/uart_rx_deframer.sv
// Oversampling UART receiver: recovers start/data/parity/stop and pushes good bytes to the RX FIFO.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority vote at every sample point.
module uart_rx_deframer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 rx_tick,
  input  logic                 rxd,
  input  logic                 p_enbl,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] dout,
  output logic                 write_en,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 error
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] C_START  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] C_BIT    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                state_q, state_d;
  logic                  rxd_meta_q, rxd_meta_d, rxd_s_q, rxd_s_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d, dout_q, dout_d;
  logic                  pen_q, pen_d, par_bad_q, par_bad_d;
  logic                  write_en_q, write_en_d, frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d, overrun_err_q, overrun_err_d;
  logic                  error_q, error_d;
  logic [TW-1:0]         c_pt;
  logic                  at_pt, samp;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]            vote_q, vote_d;
`endif

  always_comb begin
    rxd_meta_d    = rxd;
    rxd_s_d       = rxd_meta_q;
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    dout_d        = dout_q;
    pen_d         = pen_q;
    par_bad_d     = par_bad_q;
    write_en_d    = 1'b0;
    frame_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    overrun_err_d = 1'b0;
    c_pt          = (state_q == START) ? C_START : C_BIT;
    at_pt         = rx_tick && (tick_cnt_q == c_pt);
`ifdef UART_RX_MAJORITY_EN
    // Two earlier votes are captured on the ticks just before the sample point.
    vote_d = vote_q;
    if (rx_tick && (tick_cnt_q == c_pt - TW'(2))) vote_d[0] = rxd_s_q;
    if (rx_tick && (tick_cnt_q == c_pt - TW'(1))) vote_d[1] = rxd_s_q;
    samp = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s_q) | (vote_q[1] & rxd_s_q);
`else
    samp = rxd_s_q;
`endif
    if (rx_tick && state_q != IDLE && state_q != WAIT_HIGH)
      tick_cnt_d = at_pt ? '0 : tick_cnt_q + TW'(1);

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (!rxd_s_q) state_d = START;
      end
      START: if (at_pt) begin
        if (!samp) begin
          state_d   = DATA;
          pen_d     = p_enbl;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (at_pt) begin
        shift_d = {samp, shift_q[DATA_BITS-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = pen_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      PARITY: if (at_pt) begin
        par_bad_d = (^shift_q) ^ samp;
        state_d   = STOP;
      end
      STOP: if (at_pt) begin
        if (!samp) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end else begin
          state_d = IDLE;
          if (par_bad_q)      parity_err_d  = 1'b1;
          else if (fifo_full) overrun_err_d = 1'b1;
          else begin
            write_en_d = 1'b1;
            dout_d     = shift_q;
          end
        end
      end
      // A held-low line must not be decoded as back-to-back 0x00 frames.
      WAIT_HIGH: if (rxd_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    error_d = frame_err_d | parity_err_d | overrun_err_d;
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      rxd_meta_q    <= 1'b1;
      rxd_s_q       <= 1'b1;
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      dout_q        <= '0;
      pen_q         <= 1'b0;
      par_bad_q     <= 1'b0;
      write_en_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      error_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_q        <= 2'b11;
`endif
    end else begin
      rxd_meta_q    <= rxd_meta_d;
      rxd_s_q       <= rxd_s_d;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      dout_q        <= dout_d;
      pen_q         <= pen_d;
      par_bad_q     <= par_bad_d;
      write_en_q    <= write_en_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      error_q       <= error_d;
`ifdef UART_RX_MAJORITY_EN
      vote_q        <= vote_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign write_en    = write_en_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign error       = error_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: frames are driven at tick granularity and each frame's outcome
// is predicted from the framing rules (stop, even parity, fifo_full) and compared with pulse counts.
module tb_uart_rx_deframer;
  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       p_enbl = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] dout;
  logic       write_en, busy, frame_err, parity_err, overrun_err, error;

  uart_rx_deframer #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .areset(areset), .rx_tick(rx_tick), .rxd(rxd), .p_enbl(p_enbl),
    .fifo_full(fifo_full), .dout(dout), .write_en(write_en), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err), .error(error)
  );

  always #5 clk = ~clk;

  // One rx_tick every 4 clocks.
  int tc = 0;
  initial forever begin
    @(negedge clk);
    tc++;
    rx_tick = (tc % 4 == 0);
  end

  // Monitor: counts pulse-cycles and captures pushed data.
  int n_we = 0, n_fe = 0, n_pe = 0, n_oe = 0, n_er = 0, n_orbad = 0;
  logic [7:0] we_data = '0;
  initial forever begin
    @(negedge clk);
    if (write_en) begin n_we++; we_data = dout; end
    if (frame_err)   n_fe++;
    if (parity_err)  n_pe++;
    if (overrun_err) n_oe++;
    if (error)       n_er++;
    if (error !== (frame_err | parity_err | overrun_err)) n_orbad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0, n_err = 0;
  logic [7:0] last_push = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int total();
    return n_we + n_fe + n_pe + n_oe + n_er;
  endfunction

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    wait_ticks(16);
  endtask

  // Drives one frame, predicts its single outcome, then idles the line for 2 bit times.
  task automatic frame(input string nm, input logic [7:0] d, input logic pen, input logic pbit,
                       input logic stp, input logic full, input int hold, input int glitch);
    int s_we, s_fe, s_pe, s_oe, s_er, s_tot;
    logic e_fe, e_pe, e_oe, e_we;
    s_we = n_we; s_fe = n_fe; s_pe = n_pe; s_oe = n_oe; s_er = n_er; s_tot = total();
    p_enbl = pen;
    fifo_full = full;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        rxd = d[i]; wait_ticks(7);
        rxd = ~d[i]; wait_ticks(1);
        rxd = d[i]; wait_ticks(8);
      end else begin
        send_bit(d[i]);
      end
    end
    if (pen) send_bit(pbit);
    send_bit(stp);

    e_fe = !stp;
    e_pe = stp && pen && ((^d) ^ pbit);
    e_oe = stp && !e_pe && full;
    e_we = stp && !e_pe && !full;
    if (e_we) last_push = d;

    chk($sformatf("%s.write_en", nm), 32'(n_we - s_we), 32'(e_we));
    chk($sformatf("%s.frame_err", nm), 32'(n_fe - s_fe), 32'(e_fe));
    chk($sformatf("%s.parity_err", nm), 32'(n_pe - s_pe), 32'(e_pe));
    chk($sformatf("%s.overrun_err", nm), 32'(n_oe - s_oe), 32'(e_oe));
    chk($sformatf("%s.error", nm), 32'(n_er - s_er), 32'(e_fe) + 32'(e_pe) + 32'(e_oe));
    if (e_we) chk($sformatf("%s.dout", nm), 32'(we_data), 32'(d));
    chk($sformatf("%s.busy_after_stop", nm), 32'(busy), 32'(e_fe));
    if (e_fe) begin
      for (int h = 0; h < hold; h++) send_bit(1'b0);
      chk($sformatf("%s.break_busy", nm), 32'(busy), 32'd1);
      chk($sformatf("%s.break_quiet", nm), 32'(total() - s_tot), 32'd2);
    end
    rxd = 1'b1;
    wait_ticks(32);
    chk($sformatf("%s.busy_idle", nm), 32'(busy), 32'd0);
    chk($sformatf("%s.dout_hold", nm), 32'(dout), 32'(last_push));
    chk($sformatf("%s.error_or", nm), 32'(n_orbad), 32'd0);
    p_enbl = 1'b0;
    fifo_full = 1'b0;
  endtask

  initial begin
    int s;
    logic [7:0] d;
    logic       pen, pb, stp, full;

    repeat (5) @(posedge clk);
    #1;
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.write_en", 32'(write_en), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.errors", 32'({frame_err, parity_err, overrun_err, error}), 32'd0);
    areset = 1'b1;
    wait_ticks(32);

    frame("good_a5", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
    frame("par_ok_23", 8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1);
    frame("par_bad_23", 8'h23, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1);

    // False start: line low for 4 ticks only.
    s = total();
    rxd = 1'b0;
    wait_ticks(2);
    chk("false_start.busy_start", 32'(busy), 32'd1);
    wait_ticks(2);
    rxd = 1'b1;
    wait_ticks(28);
    chk("false_start.busy_end", 32'(busy), 32'd0);
    chk("false_start.quiet", 32'(total() - s), 32'd0);

`ifdef UART_RX_MAJORITY_EN
    frame("glitch_00", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3);
`endif

    frame("break_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 3, -1);
    frame("after_break_31", 8'h31, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
    frame("overrun_47", 8'h47, 1'b0, 1'b0, 1'b1, 1'b1, 0, -1);
    frame("after_ovr_57", 8'h57, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);

    // Reset during data bit 5 of 0x63.
    s = total();
    d = 8'h63;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    rxd = d[5];
    wait_ticks(8);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid.dout", 32'(dout), 32'd0);
    chk("rst_mid.write_en", 32'(write_en), 32'd0);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.errors", 32'({frame_err, parity_err, overrun_err, error}), 32'd0);
    areset = 1'b1;
    rxd = 1'b1;
    last_push = '0;
    wait_ticks(40);
    chk("rst_mid.quiet", 32'(total() - s), 32'd0);
    frame("after_rst_70", 8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);

    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      pb   = (^d) ^ ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 7) != 0);
      full = ($urandom_range(0, 4) == 0);
      frame($sformatf("rnd%0d", n), d, pen, pb, stp, full, int'($urandom_range(0, 3)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Oversampling UART receiver. Takes the serial line and the 16x sample tick from the baud generator.
- Recovers start, data, optional parity and stop bits, then pushes each good byte into the RX FIFO with a one-cycle write strobe.
- Sits between the baud generator / serial pin and the RX FIFO; it is the receive-side counterpart of the transmitter.
- Reports framing, parity and overrun errors as single-cycle pulses and as an aggregated error pulse.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first (legal range 5..8).
- OVERSAMPLE, 16, sample ticks per bit period (even, at least 8).

Ports:
- clk, input, 1, system clock.
- areset, input, 1, reset: synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- rx_tick, input, 1, one-clk pulse at OVERSAMPLE x the baud rate, from the baud generator.
- rxd, input, 1, serial line; idles high; asynchronous to clk.
- p_enbl, input, 1, 1 = an even-parity bit follows the data; sampled at start-bit validation.
- fifo_full, input, 1, RX FIFO full flag.
- dout, output, DATA_BITS, received byte; valid while write_en = 1.
- write_en, output, 1, one-clk push strobe to the RX FIFO.
- busy, output, 1, high from start-bit detection until return to IDLE.
- frame_err, output, 1, one-clk pulse when the stop bit is sampled as 0.
- parity_err, output, 1, one-clk pulse on parity mismatch.
- overrun_err, output, 1, one-clk pulse when a good byte is dropped because fifo_full = 1.
- error, output, 1, OR of the three error pulses.

Behaviour:
- Reset values: all outputs 0 (dout = 0), state IDLE, counters 0, synchroniser flops = 1.
- Line synchroniser: rxd passes through 2 flops (rxd_s). All decisions below use rxd_s.
- Counters advance only on rx_tick:
  - tick_cnt has width clog2(OVERSAMPLE).
  - bit_cnt has width clog2(DATA_BITS).
- IDLE:
  - rxd_s = 0 -> go to START, clear tick_cnt, set busy = 1.
- START, on each rx_tick:
  - When tick_cnt = OVERSAMPLE/2-1, sample the line.
  - Sample = 0 -> clear tick_cnt, latch p_enbl, go to DATA.
  - Sample = 1 -> false start; go to IDLE with no pulses.
- DATA:
  - When tick_cnt = OVERSAMPLE-1 (bit centre), shift the sample into the MSB of the shift register (LSB-first reception).
  - After DATA_BITS samples, go to PARITY if the latched p_enbl = 1, else to STOP.
- PARITY:
  - Sample at bit centre.
  - par_bad = XOR of all data bits XOR the sampled parity bit (even parity).
  - Go to STOP.
- STOP, sample at bit centre, then branch:
  - Sample = 0: pulse frame_err; no push; go to WAIT_HIGH.
  - Sample = 1 and par_bad: pulse parity_err; no push; go to IDLE.
  - Sample = 1, good byte, fifo_full = 1: pulse overrun_err; byte dropped; go to IDLE.
  - Sample = 1, good byte, fifo_full = 0: write_en = 1 for exactly one clk, with dout = byte; go to IDLE.
- Output timing:
  - write_en and the error pulses are registered; they assert on the clk edge that follows the stop-sample tick.
  - dout holds its last value when write_en = 0.
- WAIT_HIGH (line break or stuck-low line):
  - Stay until rxd_s = 1, then go to IDLE.
  - This prevents a held-low line from being decoded as repeated 0x00 frames.
- busy = 1 in every state except IDLE.
- fifo_full is evaluated only in the push cycle. The block has no internal storage beyond one frame.
- Reset mid-frame: the next clk with areset = 0 forces IDLE and all-zero outputs. The partial byte is discarded and nothing is pushed.
- rx_tick arriving in the same clk as a state change is used by the new state on the next tick only. No tick is counted twice.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample point (start validation, data, parity, stop) uses a 2-of-3 majority vote.
  - The votes are taken on rx_ticks at tick_cnt = C-2, C-1 and C, where C is the single-sample point.
  - A single-tick glitch near the bit centre is rejected.
- Undefined: a single sample is taken at tick_cnt = C.
- Frame timing and output latency are identical in both builds.

Test Plan:
- Good frame: p_enbl = 0, OVERSAMPLE = 16, rx_tick every 4 clks, send 0xA5 with stop = 1 -> exactly one write_en pulse with dout = 0xA5, no error pulses, busy low after the stop bit.
- Parity frame: p_enbl = 1, send 0x23 with parity bit 1 -> push 0x23. Resend 0x23 with parity bit 0 -> parity_err and error pulse once, no write_en.
- False start and glitch: drive rxd low for 4 ticks, then high -> no busy beyond START, no write_en. With UART_RX_MAJORITY_EN, a 1-tick high glitch at the centre of data bit 3 of 0x00 -> dout = 0x00.
- Break and framing error: send 0x55 with stop = 0, hold rxd low for 3 bit times -> one frame_err pulse, no write_en, no further frames until rxd rises. A following 0x31 frame is then pushed correctly.
- Overrun: fifo_full = 1 during the push cycle of 0x47 -> overrun_err pulse, write_en stays 0. Next frame 0x57 with fifo_full = 0 -> pushed.
- Reset mid-frame: assert areset = 0 during data bit 5 of 0x63, release, then send 0x70 -> only 0x70 is pushed; all outputs are 0 in the clk after reset is sampled.
